// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_pkg
// Brief    : Shared widths, types and ALU op encodings for the EX operand stage.
// Revision : 1.0
// ============================================================================
package ex_operand_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] reg_t;
    typedef logic [OP_W-1:0]   op_t;

    typedef enum logic [OP_W-1:0] {
        OP_LBI = 3'b000,
        OP_XOR = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_OR  = 3'b100,
        OP_AND = 3'b101,
        OP_ADD = 3'b110,
        OP_SUB = 3'b111
    } alu_op_e;

    // Writer hits a reader when it is live, writes, and targets the same full-width tag.
    function automatic logic tag_hit(input logic live, input logic wr_en,
                                     input reg_t wr_tag, input reg_t rd_tag);
        return live & wr_en & (wr_tag == rd_tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_if
// Brief    : Decode/RF/forwarding/ALU bus around the EX operand stage.
// Revision : 1.0
// ============================================================================
interface ex_operand_stage_if;
    import ex_operand_stage_pkg::*;

    logic  idValid;
    logic  idReady;
    op_t   idOp;
    reg_t  idRs1;
    reg_t  idRs2;
    reg_t  idRd;
    logic  idWrEn;
    logic  idUseImm;
    data_t idImm;
    data_t rfData1;
    data_t rfData2;
    data_t exResult;
    data_t wbData;
    reg_t  wbRd;
    logic  wbWrEn;
    logic  stall;
    logic  flush;
    logic  exValid;
    op_t   exOp;
    data_t exSrc1;
    data_t exSrc2;
    reg_t  exRd;
    logic  exWrEn;

    modport master (
        output idValid, idOp, idRs1, idRs2, idRd, idWrEn, idUseImm, idImm,
               rfData1, rfData2, exResult, wbData, wbRd, wbWrEn, stall, flush,
        input  idReady, exValid, exOp, exSrc1, exSrc2, exRd, exWrEn
    );

    modport slave (
        input  idValid, idOp, idRs1, idRs2, idRd, idWrEn, idUseImm, idImm,
               rfData1, rfData2, exResult, wbData, wbRd, wbWrEn, stall, flush,
        output idReady, exValid, exOp, exSrc1, exSrc2, exRd, exWrEn
    );
endinterface
`default_nettype wire

// File: rtl/ex_operand_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage_fwd
// Brief    : Per-source operand forwarding mux (EX > WB > register file).
// Revision : 1.0
// ============================================================================
module ex_operand_stage_fwd
    import ex_operand_stage_pkg::*;
(
    input  reg_t  tag_i,
    input  data_t rf_data_i,
    input  logic  ex_valid_i,
    input  logic  ex_wr_en_i,
    input  reg_t  ex_rd_i,
    input  data_t ex_result_i,
    input  logic  wb_wr_en_i,
    input  reg_t  wb_rd_i,
    input  data_t wb_data_i,
    output data_t data_o,
    output logic  wb_hit_o
);
    logic w_ex_hit;

    assign w_ex_hit = tag_hit(ex_valid_i, ex_wr_en_i, ex_rd_i, tag_i);
    assign wb_hit_o = tag_hit(1'b1, wb_wr_en_i, wb_rd_i, tag_i);

    // EX holds the younger producer, so it shadows a same-tag WB write.
    assign data_o = w_ex_hit ? ex_result_i :
                    wb_hit_o ? wb_data_i   : rf_data_i;

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Brief    : Decode->execute pipeline register with operand forwarding,
//            stall hold (with WB refresh) and branch flush.
// Revision : 1.0
// ============================================================================
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ex_operand_stage_if.slave  bus
);
    logic  valid_q;
    logic  wr_en_q;
    op_t   op_q;
    data_t src1_q;
    data_t src2_q;
    reg_t  rd_q;
    reg_t  rs1_q;
    reg_t  rs2_q;
    logic  use_imm_q;

    reg_t  w_tag1;
    reg_t  w_tag2;
    data_t w_fwd1;
    data_t w_fwd2;
    logic  w_wb_hit1;
    logic  w_wb_hit2;

    // While stalled the muxes look at the held tags so WB can refresh stale operands.
    assign w_tag1 = bus.stall ? rs1_q : bus.idRs1;
    assign w_tag2 = bus.stall ? rs2_q : bus.idRs2;

    ex_operand_stage_fwd u_fwd1 (
        .tag_i       (w_tag1),
        .rf_data_i   (bus.rfData1),
        .ex_valid_i  (valid_q),
        .ex_wr_en_i  (wr_en_q),
        .ex_rd_i     (rd_q),
        .ex_result_i (bus.exResult),
        .wb_wr_en_i  (bus.wbWrEn),
        .wb_rd_i     (bus.wbRd),
        .wb_data_i   (bus.wbData),
        .data_o      (w_fwd1),
        .wb_hit_o    (w_wb_hit1)
    );

    ex_operand_stage_fwd u_fwd2 (
        .tag_i       (w_tag2),
        .rf_data_i   (bus.rfData2),
        .ex_valid_i  (valid_q),
        .ex_wr_en_i  (wr_en_q),
        .ex_rd_i     (rd_q),
        .ex_result_i (bus.exResult),
        .wb_wr_en_i  (bus.wbWrEn),
        .wb_rd_i     (bus.wbRd),
        .wb_data_i   (bus.wbData),
        .data_o      (w_fwd2),
        .wb_hit_o    (w_wb_hit2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else if (bus.stall) begin
            if (w_wb_hit1)
                src1_q <= bus.wbData;
            if (w_wb_hit2 && !use_imm_q)
                src2_q <= bus.wbData;
        end else begin
            valid_q   <= bus.idValid;
            wr_en_q   <= bus.idValid & bus.idWrEn;
            op_q      <= bus.idOp;
            src1_q    <= w_fwd1;
            src2_q    <= bus.idUseImm ? bus.idImm : w_fwd2;
            rd_q      <= bus.idRd;
            rs1_q     <= bus.idRs1;
            rs2_q     <= bus.idRs2;
            use_imm_q <= bus.idUseImm;
        end
    end

    assign bus.idReady = ~bus.stall & ~rst;
    assign bus.exValid = valid_q;
    assign bus.exOp    = op_q;
    assign bus.exSrc1  = src1_q;
    assign bus.exSrc2  = src2_q;
    assign bus.exRd    = rd_q;
    assign bus.exWrEn  = wr_en_q & valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Brief    : Directed self-checking bench for ex_operand_stage.
// Revision : 1.0
// ============================================================================
module tb_ex_operand_stage;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] op,
                           input logic [15:0] s1, input logic [15:0] s2,
                           input logic [2:0] rd, input logic we);
        chk({tag, ".exValid"}, {31'd0, bus.exValid}, {31'd0, v});
        chk({tag, ".exOp"},    {29'd0, bus.exOp},    {29'd0, op});
        chk({tag, ".exSrc1"},  {16'd0, bus.exSrc1},  {16'd0, s1});
        chk({tag, ".exSrc2"},  {16'd0, bus.exSrc2},  {16'd0, s2});
        chk({tag, ".exRd"},    {29'd0, bus.exRd},    {29'd0, rd});
        chk({tag, ".exWrEn"},  {31'd0, bus.exWrEn},  {31'd0, we});
    endtask

    task automatic set_id(input logic v, input logic [2:0] op, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [2:0] rd, input logic we,
                          input logic imm_sel, input logic [15:0] imm,
                          input logic [15:0] rf1, input logic [15:0] rf2);
        bus.idValid  = v;
        bus.idOp     = op;
        bus.idRs1    = rs1;
        bus.idRs2    = rs2;
        bus.idRd     = rd;
        bus.idWrEn   = we;
        bus.idUseImm = imm_sel;
        bus.idImm    = imm;
        bus.rfData1  = rf1;
        bus.rfData2  = rf2;
    endtask

    task automatic set_wb(input logic we, input logic [2:0] rd, input logic [15:0] d);
        bus.wbWrEn = we;
        bus.wbRd   = rd;
        bus.wbData = d;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.exResult = 16'h0000;
        set_wb(1'b0, 3'd0, 16'h0000);
        set_id(1'b1, 3'b111, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h00AA, 16'h1111, 16'h2222);

        // Reset held two cycles with a valid instruction presented
        step();
        step();
        chk_out("reset", 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        chk("reset.idReady", {31'd0, bus.idReady}, 32'd0);
        rst = 1'b0;
        #1;
        chk("release.idReady", {31'd0, bus.idReady}, 32'd1);

        // Basic capture: ADD r1(=5) + imm 3, rd=2 writes
        set_id(1'b1, 3'b110, 3'd1, 3'd6, 3'd2, 1'b1, 1'b1, 16'h0003, 16'h0005, 16'h7777);
        step();
        chk_out("capture", 1'b1, 3'b110, 16'h0005, 16'h0003, 3'd2, 1'b1);

        // EX hit on rs1=2 beats WB hit on same tag; rs2 from register file
        bus.exResult = 16'h1234;
        set_wb(1'b1, 3'd2, 16'h5555);
        set_id(1'b1, 3'b111, 3'd2, 3'd5, 3'd4, 1'b0, 1'b0, 16'h0000, 16'hDEAD, 16'h0042);
        step();
        chk_out("exfwd", 1'b1, 3'b111, 16'h1234, 16'h0042, 3'd4, 1'b0);

        // Held rd=4 does not write, so rs1=4 reads RF; rs2=3 from WB
        bus.exResult = 16'h9999;
        set_wb(1'b1, 3'd3, 16'h00FF);
        set_id(1'b1, 3'b001, 3'd4, 3'd3, 3'd6, 1'b1, 1'b0, 16'h0000, 16'h0777, 16'h0BAD);
        step();
        chk_out("wbfwd", 1'b1, 3'b001, 16'h0777, 16'h00FF, 3'd6, 1'b1);

        // Capture the instruction that will be stalled: rs1=7, rs2=4 (reg)
        set_wb(1'b0, 3'd0, 16'h0000);
        set_id(1'b1, 3'b101, 3'd7, 3'd4, 3'd5, 1'b1, 1'b0, 16'h0000, 16'h0AAA, 16'h0001);
        step();
        chk_out("prestall", 1'b1, 3'b101, 16'h0AAA, 16'h0001, 3'd5, 1'b1);

        // Stall 3 cycles; WB writes r4 in the second cycle
        bus.stall = 1'b1;
        set_id(1'b1, 3'b010, 3'd4, 3'd4, 3'd1, 1'b1, 1'b0, 16'h0000, 16'h3333, 16'h4444);
        #1;
        chk("stall1.idReady", {31'd0, bus.idReady}, 32'd0);
        step();
        chk_out("stall1", 1'b1, 3'b101, 16'h0AAA, 16'h0001, 3'd5, 1'b1);
        set_wb(1'b1, 3'd4, 16'hBEEF);
        #1;
        chk("stall2.idReady", {31'd0, bus.idReady}, 32'd0);
        step();
        chk_out("stall2", 1'b1, 3'b101, 16'h0AAA, 16'hBEEF, 3'd5, 1'b1);
        set_wb(1'b0, 3'd0, 16'h0000);
        #1;
        chk("stall3.idReady", {31'd0, bus.idReady}, 32'd0);
        step();
        chk_out("stall3", 1'b1, 3'b101, 16'h0AAA, 16'hBEEF, 3'd5, 1'b1);

        // Flush wins over stall
        bus.flush = 1'b1;
        step();
        chk("flush.exValid", {31'd0, bus.exValid}, 32'd0);
        chk("flush.exWrEn",  {31'd0, bus.exWrEn},  32'd0);

        // Release; next valid instruction captured normally (no EX hit from killed slot)
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_id(1'b1, 3'b100, 3'd5, 3'd2, 3'd1, 1'b1, 1'b1, 16'h2222, 16'h1111, 16'h6666);
        step();
        chk_out("postflush", 1'b1, 3'b100, 16'h1111, 16'h2222, 3'd1, 1'b1);

        // Held immediate src2 ignores a WB hit on its rs2 tag during stall
        bus.stall = 1'b1;
        set_wb(1'b1, 3'd2, 16'hFFFF);
        step();
        chk_out("immhold", 1'b1, 3'b100, 16'h1111, 16'h2222, 3'd1, 1'b1);

        // Bubble: idValid=0 clears exValid and exWrEn
        bus.stall = 1'b0;
        set_wb(1'b0, 3'd0, 16'h0000);
        set_id(1'b0, 3'b011, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 16'h0000, 16'h0123, 16'h0456);
        step();
        chk("bubble.exValid", {31'd0, bus.exValid}, 32'd0);
        chk("bubble.exWrEn",  {31'd0, bus.exWrEn},  32'd0);

        // Valid again, then reset mid-stall
        set_id(1'b1, 3'b011, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, 16'h0000, 16'h0123, 16'h0456);
        step();
        chk_out("recap", 1'b1, 3'b011, 16'h0123, 16'h0456, 3'd7, 1'b1);
        bus.stall = 1'b1;
        rst = 1'b1;
        step();
        chk_out("rststall", 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0);
        chk("rststall.idReady", {31'd0, bus.idReady}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
